// File: rtl/interleaved_modmul_if.sv
// Request/result bundle for interleaved_modmul; the mode signal exists only
// when MODMUL_GF2M_EN is defined.
interface interleaved_modmul_if #(
  parameter int N = 231
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N:0]   p;
`ifdef MODMUL_GF2M_EN
  logic         mode;
`endif
  logic         busy;
  logic         done;
  logic [N-1:0] m;

`ifdef MODMUL_GF2M_EN
  modport master (output start, a, b, p, mode, input busy, done, m);
  modport slave  (input start, a, b, p, mode, output busy, done, m);
`else
  modport master (output start, a, b, p, input busy, done, m);
  modport slave  (input start, a, b, p, output busy, done, m);
`endif
endinterface

// File: rtl/interleaved_modmul.sv
// Bit-serial interleaved modular multiplier, one bit of b per cycle, MSB first.
// Optional binary-field datapath enabled by defining MODMUL_GF2M_EN.
module interleaved_modmul #(
  parameter int N  = 231,
  parameter int CW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  interleaved_modmul_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N+1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_m;
`ifdef MODMUL_GF2M_EN
  logic [N:0]    r_p;
  logic          r_mode;
  logic [N:0]    w_g_sh;
  logic [N:0]    w_g_red;
  logic [N:0]    w_g_add;
`else
  logic [N-1:0]  r_p;
`endif

  logic          w_bit;
  logic          w_last;
  logic [N+1:0]  w_pe;
  logic [N+1:0]  w_dbl;
  logic [N+1:0]  w_red1;
  logic [N+1:0]  w_sum;
  logic [N+1:0]  w_red2;
  logic [N+1:0]  w_acc_nxt;

  assign w_bit  = r_b[r_cnt];
  assign w_last = (r_cnt == '0);
  // The prime-field path ignores p[N]; in prime mode it is zero by contract.
  assign w_pe   = {2'b00, r_p[N-1:0]};

  // One interleaved step; N+2 bits keep 2R and R+a free of overflow.
  always_comb begin
    w_dbl     = {r_acc[N:0], 1'b0};
    w_red1    = (w_dbl >= w_pe) ? (w_dbl - w_pe) : w_dbl;
    w_sum     = w_bit ? (w_red1 + {2'b00, r_a}) : w_red1;
    w_red2    = (w_sum >= w_pe) ? (w_sum - w_pe) : w_sum;
    w_acc_nxt = w_red2;
`ifdef MODMUL_GF2M_EN
    w_g_sh    = {r_acc[N-1:0], 1'b0};
    w_g_red   = w_g_sh[N] ? (w_g_sh ^ r_p) : w_g_sh;
    w_g_add   = w_bit ? (w_g_red ^ {1'b0, r_a}) : w_g_red;
    if (r_mode) begin
      w_acc_nxt = {1'b0, w_g_add};
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned and infers a latch.
    w_state_nxt = r_state;
    bus.busy    = (r_state != IDLE);
    bus.done    = 1'b0;
    unique case (r_state)
      IDLE: if (bus.start) w_state_nxt = RUN;
      RUN:  if (w_last)    w_state_nxt = DONE;
      DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_m    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
`ifdef MODMUL_GF2M_EN
      r_mode <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: if (bus.start) begin
          r_a    <= bus.a;
          r_b    <= bus.b;
`ifdef MODMUL_GF2M_EN
          r_p    <= bus.p;
          r_mode <= bus.mode;
`else
          r_p    <= bus.p[N-1:0];
`endif
          r_acc  <= '0;
          r_cnt  <= CW'(N - 1);
        end
        RUN: begin
          r_acc <= w_acc_nxt;
          if (w_last) begin
            r_m <= w_acc_nxt[N-1:0];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.m = r_m;

endmodule

// File: tb/tb_interleaved_modmul.sv
// Directed self-checking bench for interleaved_modmul at N=8; binary-field
// vectors run only when MODMUL_GF2M_EN is defined.
module tb_interleaved_modmul;
  localparam int N = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic mode_sel;

  interleaved_modmul_if #(.N(N)) bus ();

  interleaved_modmul #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble the inputs after acceptance, then check
  // latency, result and the return to idle.
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [8:0] ip, input logic [7:0] exp);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    bus.p     = ip;
`ifdef MODMUL_GF2M_EN
    bus.mode  = mode_sel;
`endif
    @(posedge clk); #1;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~ia;
    bus.b     = ~ib;
    bus.p     = '0;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) break;
    end
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_m"}, 32'(bus.m), 32'(exp));
    @(posedge clk); #1;
    check({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int ndone;
    int last;
    int seen;
    checks   = 0;
    errors   = 0;
    mode_sel = 1'b0;
    reset    = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.p     = '0;
`ifdef MODMUL_GF2M_EN
    bus.mode  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_m", 32'(bus.m), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Prime-field vectors, p = 251 unless noted.
    run_op("p251_200x100", 8'd200, 8'd100, 9'd251, 8'd171);
    run_op("p251_250x250", 8'd250, 8'd250, 9'd251, 8'd1);
    run_op("p251_0x77",    8'd0,   8'd77,  9'd251, 8'd0);
    run_op("p251_1x123",   8'd1,   8'd123, 9'd251, 8'd123);
    run_op("p251_17x15",   8'd17,  8'd15,  9'd251, 8'd4);
    run_op("p13_7x9",      8'd7,   8'd9,   9'd13,  8'd11);
`ifndef MODMUL_GF2M_EN
    run_op("pN_ignored",   8'd200, 8'd100, 9'h1FB, 8'd171);
`endif

`ifdef MODMUL_GF2M_EN
    mode_sel = 1'b1;
    run_op("gf2m_53xCA", 8'h53, 8'hCA, 9'h11B, 8'h01);
    run_op("gf2m_57x83", 8'h57, 8'h83, 9'h11B, 8'hC1);
    mode_sel = 1'b0;
    run_op("gfp_after_gf2m", 8'd250, 8'd250, 9'd251, 8'd1);
`endif

    // start held high: accept at edges 1, 11, 21, 31; done after 9, 19, 29.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd200;
    bus.b     = 8'd100;
    bus.p     = 9'd251;
    ndone = 0;
    last  = -1;
    for (int e = 1; e <= 35; e++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (last >= 0) check("b2b_gap", 32'(e - last), 32'd10);
        last = e;
        ndone++;
      end
      if (ndone > 0) check("b2b_m_stable", 32'(bus.m), 32'd171);
    end
    check("b2b_count", 32'(ndone), 32'd3);
    @(negedge clk);
    bus.start = 1'b0;
    seen = 0;
    while (bus.busy && seen < 20) begin
      @(posedge clk); #1;
      seen++;
    end
    check("b2b_drain", 32'(bus.busy), 32'd0);

    // Reset four cycles into RUN aborts the operation without a done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd17;
    bus.b     = 8'd15;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_m", 32'(bus.m), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_op("post_abort_250x250", 8'd250, 8'd250, 9'd251, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
